// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types, defaults and sizing helper for the synchronous FIFO
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int AE_DEFAULT = 2;
    localparam int AF_MARGIN  = 2;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: register array with one write port and one asynchronous read port
module fifo_mem #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]    rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // storage is intentionally not reset; only accepted writes touch it
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_pro.sv
// fifo_sync_pro: count-based synchronous FIFO with thresholds, FWFT option and sticky errors
module fifo_sync_pro
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 16,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - AF_MARGIN,
    parameter int AE_THRESH  = AE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       r_en,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       data_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync_pro: DEPTH must be a power of two and at least 2");
    end
    if (AF_THRESH < 0 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_thresh
        $error("fifo_sync_pro: thresholds must lie within 0..DEPTH");
    end

    logic [PW-1:0]         w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d, rd_data;
    logic                  dv_q, dv_d, ovf_q, ovf_d, udf_q, udf_d;
    logic                  r_acc, w_acc;

    assign empty        = count_q == '0;
    assign full         = count_q == CW'(DEPTH);
    assign almost_full  = count_q >= CW'(AF_THRESH);
    assign almost_empty = count_q <= CW'(AE_THRESH);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // a read frees a slot, so a full FIFO still takes a write alongside an accepted read
    assign r_acc = r_en & ~empty;
    assign w_acc = w_en & (~full | r_acc);

    fifo_mem #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
        .clk     (clk),
        .we_i    (w_acc),
        .waddr_i (w_ptr_q),
        .wdata_i (data_in),
        .raddr_i (r_ptr_q),
        .rdata_o (rd_data)
    );

    // next-state for pointers, occupancy, read register and sticky error flags
    always_comb begin
        w_ptr_d = w_ptr_q + PW'(w_acc);
        r_ptr_d = r_ptr_q + PW'(r_acc);
        count_d = count_q + CW'(w_acc) - CW'(r_acc);
        dout_d  = (MODE == FIFO_STD && r_acc) ? rd_data : dout_q;
        dv_d    = MODE == FIFO_STD && r_acc;
        ovf_d   = (w_en & ~w_acc) ? 1'b1 : clr_err ? 1'b0 : ovf_q;
        udf_d   = (r_en & ~r_acc) ? 1'b1 : clr_err ? 1'b0 : udf_q;
    end

    // state registers; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign data_out   = (MODE == FIFO_FWFT) ? rd_data : dout_q;
    assign data_valid = (MODE == FIFO_FWFT) ? ~empty : dv_q;

endmodule

// File: tb/tb_fifo_sync_pro.sv
// tb_fifo_sync_pro: directed checks of a standard-mode and an FWFT-mode FIFO
module tb_fifo_sync_pro;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        w_en = 1'b0, r_en = 1'b0, clr_err = 1'b0;
    logic [15:0] data_in = '0, data_out;
    logic        data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0]  count;

    logic        f_w_en = 1'b0, f_r_en = 1'b0, f_clr_err = 1'b0;
    logic [15:0] f_data_in = '0, f_data_out;
    logic        f_data_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [2:0]  f_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_sync_pro #(.DEPTH(8), .DATA_WIDTH(16), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    fifo_sync_pro #(.DEPTH(4), .DATA_WIDTH(16), .FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .w_en(f_w_en), .data_in(f_data_in), .r_en(f_r_en),
        .data_out(f_data_out), .data_valid(f_data_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow), .clr_err(f_clr_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] base);
        for (int i = 0; i < 8; i++) begin
            w_en = 1'b1;
            data_in = base + 16'(i);
            tick();
        end
        w_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_af", 32'(almost_full), 0);
        check("rst_dout", 32'(data_out), 0);
        check("rst_dv", 32'(data_valid), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_udf", 32'(underflow), 0);
        check("fw_rst_empty", 32'(f_empty), 1);
        check("fw_rst_dv", 32'(f_data_valid), 0);

        f_w_en = 1'b1;
        f_data_in = 16'hABCD;
        tick();
        f_w_en = 1'b0;
        check("fw_dout", 32'(f_data_out), 32'hABCD);
        check("fw_dv", 32'(f_data_valid), 1);
        check("fw_count", 32'(f_count), 1);
        f_r_en = 1'b1;
        tick();
        f_r_en = 1'b0;
        check("fw_pop_dv", 32'(f_data_valid), 0);
        check("fw_pop_empty", 32'(f_empty), 1);
        f_w_en = 1'b1;
        f_data_in = 16'h1111;
        tick();
        f_data_in = 16'h2222;
        tick();
        f_w_en = 1'b0;
        check("fw_head1", 32'(f_data_out), 32'h1111);
        f_r_en = 1'b1;
        tick();
        f_r_en = 1'b0;
        check("fw_head2", 32'(f_data_out), 32'h2222);
        check("fw_count2", 32'(f_count), 1);

        for (int i = 0; i < 8; i++) begin
            w_en = 1'b1;
            data_in = 16'h3C00 + 16'(i);
            tick();
            check("wr_count", 32'(count), 32'(i + 1));
            check("wr_af", 32'(almost_full), 32'(i + 1 >= 6));
            check("wr_full", 32'(full), 32'(i == 7));
        end
        data_in = 16'hDEAD;
        tick();
        w_en = 1'b0;
        check("ovf_set", 32'(overflow), 1);
        check("ovf_count", 32'(count), 8);

        for (int i = 0; i < 8; i++) begin
            r_en = 1'b1;
            tick();
            check("rd_data", 32'(data_out), 32'h3C00 + 32'(i));
            check("rd_dv", 32'(data_valid), 1);
            check("rd_count", 32'(count), 32'(7 - i));
            check("rd_ae", 32'(almost_empty), 32'(7 - i <= 2));
        end
        tick();
        r_en = 1'b0;
        check("udf_set", 32'(underflow), 1);
        check("udf_dv", 32'(data_valid), 0);
        check("udf_empty", 32'(empty), 1);
        check("udf_dout_hold", 32'(data_out), 32'h3C07);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_ovf", 32'(overflow), 0);
        check("clr_udf", 32'(underflow), 0);

        fill(16'h5000);
        for (int i = 0; i < 4; i++) begin
            w_en = 1'b1;
            r_en = 1'b1;
            data_in = 16'h4000 + 16'(i);
            tick();
            check("sim_data", 32'(data_out), 32'h5000 + 32'(i));
            check("sim_count", 32'(count), 8);
            check("sim_ovf", 32'(overflow), 0);
        end
        w_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r_en = 1'b1;
            tick();
            check("wrap_data", 32'(data_out), (i < 4) ? 32'h5004 + 32'(i) : 32'h4000 + 32'(i - 4));
        end
        r_en = 1'b0;
        check("wrap_empty", 32'(empty), 1);

        w_en = 1'b1;
        r_en = 1'b1;
        data_in = 16'h1234;
        tick();
        w_en = 1'b0;
        check("er_count", 32'(count), 1);
        check("er_udf", 32'(underflow), 1);
        check("er_dv", 32'(data_valid), 0);
        tick();
        r_en = 1'b0;
        check("er_data", 32'(data_out), 32'h1234);
        check("er_dv2", 32'(data_valid), 1);
        check("er_count2", 32'(count), 0);

        fill(16'h6000);
        w_en = 1'b1;
        tick();
        w_en = 1'b0;
        r_en = 1'b1;
        repeat (4) tick();
        r_en = 1'b0;
        check("mid_count", 32'(count), 4);
        check("mid_ovf", 32'(overflow), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_count", 32'(count), 0);
        check("mrst_empty", 32'(empty), 1);
        check("mrst_dout", 32'(data_out), 0);
        check("mrst_dv", 32'(data_valid), 0);
        check("mrst_ovf", 32'(overflow), 0);
        check("mrst_udf", 32'(underflow), 0);

        fill(16'h7000);
        w_en = 1'b1;
        clr_err = 1'b1;
        tick();
        w_en = 1'b0;
        check("clr_vs_err", 32'(overflow), 1);
        tick();
        clr_err = 1'b0;
        check("clr_after", 32'(overflow), 0);
        check("clr_count", 32'(count), 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
